// File: rtl/text_render_ctrl_if.sv
// text_render_ctrl_if
//   Memory-side bus between the text renderer and its two lookup memories.
//   master : the renderer (drives addresses, receives data)
//   slave  : text buffer RAM + character ROM (receive addresses, drive data)
//
//   tb_addr   13  text buffer read address (row*COLS+col)
//   tb_data    8  character code from the text buffer
//   rom_addr   8  character ROM address (character code)
//   rom_data  8x8 glyph bitmap, [row][bit], rows 0..7 top to bottom
interface text_render_ctrl_if;
   logic [12:0]     tb_addr;
   logic [7:0]      tb_data;
   logic [7:0]      rom_addr;
   logic [0:7][0:7] rom_data;

   modport master (output tb_addr, output rom_addr, input tb_data, input rom_data);
   modport slave  (input tb_addr, input rom_addr, output tb_data, output rom_data);
endinterface

// File: rtl/text_render_ctrl.sv
// text_render_ctrl
//   8x8 character-cell text renderer for 640x480 video (80x60 cells).
//   Four-stage pipeline, one pixel per clock, no stalls:
//     S0 pixel coordinate -> text buffer address
//     S1 character code   -> ROM address
//     S2 glyph row        -> single bitmap bit
//     S3 bit (+cursor)    -> RGB444 pixel
//   Sync and active flags are delayed by the same four stages.
//
//   The text buffer and ROM are expected to present data during the clock
//   cycle that follows the launch of their (registered) address.
//
//   Optional build macro: CURSOR_EN adds a blinking underline cursor driven
//   by a frame counter clocked from falling edges of vsync_in.
//
// Ports
//   CLK, RST            pixel clock, asynchronous active-high reset
//   pixel_col/row       pixel coordinate from the timing generator
//   video_on            active-area flag
//   hsync_in/vsync_in   raw syncs (vsync active low)
//   bus                 text buffer / character ROM bus (master side)
//   cursor_col/row      cursor cell (used only with CURSOR_EN)
//   pixel_rgb           output colour
//   hsync_out/vsync_out syncs aligned to pixel_rgb
//   active_out          video_on aligned to pixel_rgb
module text_render_ctrl #(
   parameter int          COLS         = 80,
   parameter int          ROWS         = 60,
   parameter logic [11:0] FG_COLOR     = 12'hFFF,
   parameter logic [11:0] BG_COLOR     = 12'h000,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [9:0]                pixel_col,
   input  logic [9:0]                pixel_row,
   input  logic                      video_on,
   input  logic                      hsync_in,
   input  logic                      vsync_in,
   text_render_ctrl_if.master        bus,
   input  logic [6:0]                cursor_col,
   input  logic [5:0]                cursor_row,
   output logic [11:0]               pixel_rgb,
   output logic                      hsync_out,
   output logic                      vsync_out,
   output logic                      active_out
);

   localparam logic [12:0] COLS_W     = 13'(COLS);
   localparam logic [6:0]  COLS_C     = 7'(COLS);
   localparam logic [6:0]  ROWS_C     = 7'(ROWS);
   localparam logic [7:0]  BLANK_CODE = 8'h20;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       video;
      logic       in_text;
      logic [2:0] fx;
      logic [2:0] fy;
      logic [6:0] cx;
      logic [6:0] cy;
`ifdef CURSOR_EN
      logic [6:0] ccol;
      logic [5:0] crow;
`endif
   } side_t;

   side_t       sb [4];
   side_t       s0_next;
   logic [6:0]  cell_x;
   logic [6:0]  cell_y;
   logic        s0_in_text;
   logic [12:0] s0_addr;
   logic        glyph_bit;
   logic        cursor_hit;

   // Cell coordinates are the pixel coordinate divided by 8. The product is
   // formed at full 13-bit width so 59*80+79 = 4799 never truncates; it is
   // only consumed when the cell is inside the grid.
   always_comb begin
      cell_x     = pixel_col[9:3];
      cell_y     = pixel_row[9:3];
      s0_in_text = video_on && (cell_x < COLS_C) && (cell_y < ROWS_C);
      s0_addr    = ({6'd0, cell_y} * COLS_W) + {6'd0, cell_x};

      s0_next         = '0;
      s0_next.hsync   = hsync_in;
      s0_next.vsync   = vsync_in;
      s0_next.video   = video_on;
      s0_next.in_text = s0_in_text;
      s0_next.fx      = pixel_col[2:0];
      s0_next.fy      = pixel_row[2:0];
      s0_next.cx      = cell_x;
      s0_next.cy      = cell_y;
`ifdef CURSOR_EN
      s0_next.ccol    = cursor_col;
      s0_next.crow    = cursor_row;
`endif
   end

   // Datapath and sideband pipeline. tb_addr only moves for in-grid cells so
   // the RAM is never asked for an address past the end of the buffer.
   // Out-of-grid or blanked cells fetch the space glyph instead.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 4; i++) begin
            sb[i]       <= '0;
            sb[i].hsync <= 1'b1;
            sb[i].vsync <= 1'b1;
         end
         bus.tb_addr  <= '0;
         bus.rom_addr <= BLANK_CODE;
         glyph_bit    <= 1'b0;
         pixel_rgb    <= '0;
      end else begin
         sb[0] <= s0_next;
         for (int i = 1; i < 4; i++) begin
            sb[i] <= sb[i-1];
         end
         if (s0_in_text) begin
            bus.tb_addr <= s0_addr;
         end
         bus.rom_addr <= sb[0].in_text ? bus.tb_data : BLANK_CODE;
         // Glyph bit 0 is the leftmost pixel; with the [0:7] row ordering
         // that bit sits at index 7.
         glyph_bit    <= bus.rom_data[sb[1].fy][3'd7 - sb[1].fx];
         if (!sb[2].video) begin
            pixel_rgb <= '0;
         end else begin
            pixel_rgb <= (glyph_bit ^ cursor_hit) ? FG_COLOR : BG_COLOR;
         end
      end
   end

`ifdef CURSOR_EN
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

   logic        vsync_prev;
   logic        phase_visible;
   logic [15:0] frame_cnt;

   // Frame counter advances on each vsync falling edge; every BLINK_FRAMES
   // frames the cursor toggles between visible and hidden.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vsync_prev    <= 1'b1;
         frame_cnt     <= '0;
         phase_visible <= 1'b1;
      end else begin
         vsync_prev <= vsync_in;
         if (vsync_prev && !vsync_in) begin
            if (frame_cnt == BLINK_LAST) begin
               frame_cnt     <= '0;
               phase_visible <= !phase_visible;
            end else begin
               frame_cnt <= frame_cnt + 16'd1;
            end
         end
      end
   end

   // Underline: bottom scan line of the cursor cell.
   assign cursor_hit = phase_visible
                       && (sb[2].cx == sb[2].ccol)
                       && (sb[2].cy == {1'b0, sb[2].crow})
                       && (sb[2].fy == 3'd7);
`else
   assign cursor_hit = 1'b0;
`endif

   assign hsync_out  = sb[3].hsync;
   assign vsync_out  = sb[3].vsync;
   assign active_out = sb[3].video;

   logic unused_bits;
   assign unused_bits = ^{sb[3], cursor_col, cursor_row, 32'(BLINK_FRAMES)};

endmodule

// File: tb/tb_text_render_ctrl.sv
// tb_text_render_ctrl
//   Directed + randomized bench for text_render_ctrl. Expected pixels come
//   from a cell/glyph model computed with plain arithmetic on the pixel
//   coordinate; expectations are queued per cycle and compared at the
//   pipeline depth of each output.
module tb_text_render_ctrl;

   localparam int          COLS     = 80;
   localparam int          ROWS     = 60;
   localparam logic [11:0] FG       = 12'hFFF;
   localparam logic [11:0] BG       = 12'h000;
   localparam int          BLINK    = 2;
   localparam int          CUR_COL  = 3;
   localparam int          CUR_ROW  = 2;

   logic        CLK;
   logic        RST;
   logic [9:0]  pixel_col;
   logic [9:0]  pixel_row;
   logic        video_on;
   logic        hsync_in;
   logic        vsync_in;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic [11:0] pixel_rgb;
   logic        hsync_out;
   logic        vsync_out;
   logic        active_out;

   text_render_ctrl_if bus ();

   text_render_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_FRAMES(BLINK)
   ) dut (
      .CLK(CLK), .RST(RST),
      .pixel_col(pixel_col), .pixel_row(pixel_row),
      .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .bus(bus),
      .cursor_col(cursor_col), .cursor_row(cursor_row),
      .pixel_rgb(pixel_rgb), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .active_out(active_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Text buffer and character ROM contents
   logic [7:0] tram  [0:8191];
   logic [7:0] glyph [0:255][0:7];

   always_comb begin
      bus.tb_data = tram[bus.tb_addr];
      for (int r = 0; r < 8; r++) begin
         bus.rom_data[r] = glyph[bus.rom_addr][r];
      end
   end

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        act;
      logic [12:0] tba;
      logic [7:0]  roma;
   } rec_t;

   rec_t hist [$];
   rec_t reset_rec;
   int   compared;
   int   mismatched;
   int   last_addr;
`ifdef CURSOR_EN
   int   blink_edges;
   bit   prev_vs;
`endif

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference pixel: which cell, which glyph, which bit, which colour.
   task automatic modelPixel(input int col, input int row, input bit von,
                             input bit hs, input bit vs, output rec_t r);
      int  cx, cy, fx, fy, code;
      bit  intext, px, cur;
      cx     = col / 8;
      cy     = row / 8;
      fx     = col % 8;
      fy     = row % 8;
      intext = von && (cx < COLS) && (cy < ROWS);
      if (intext) last_addr = cy * COLS + cx;
      code   = intext ? int'(tram[cy * COLS + cx]) : 32'h20;
      px     = glyph[code][fy][fx];
      cur    = 1'b0;
`ifdef CURSOR_EN
      cur = (((blink_edges / BLINK) % 2) == 0) && (cx == CUR_COL) && (cy == CUR_ROW) && (fy == 7);
`endif
      r.rgb  = !von ? 12'h000 : ((px ^ cur) ? FG : BG);
      r.hs   = hs;
      r.vs   = vs;
      r.act  = von;
      r.tba  = 13'(last_addr);
      r.roma = 8'(code);
   endtask

   task automatic checkOutput();
      int n;
      n = hist.size() - 1;
      compare("tb_addr",    32'(bus.tb_addr),  32'(hist[n].tba));
      compare("rom_addr",   32'(bus.rom_addr), 32'(hist[n-1].roma));
      compare("pixel_rgb",  32'(pixel_rgb),    32'(hist[n-3].rgb));
      compare("hsync_out",  32'(hsync_out),    32'(hist[n-3].hs));
      compare("vsync_out",  32'(vsync_out),    32'(hist[n-3].vs));
      compare("active_out", 32'(active_out),   32'(hist[n-3].act));
   endtask

   // One pixel clock: drive inputs, record the model's expectation, clock,
   // then compare every output at its own pipeline depth.
   task automatic applyStimulus(input int col, input int row, input bit von,
                                input bit hs, input bit vs, input bit rst);
      rec_t rec;
      pixel_col = 10'(col);
      pixel_row = 10'(row);
      video_on  = von;
      hsync_in  = hs;
      vsync_in  = vs;
      RST       = rst;
      if (rst) begin
         rec       = reset_rec;
         last_addr = 0;
`ifdef CURSOR_EN
         blink_edges = 0;
         prev_vs     = 1'b1;
`endif
         for (int k = 1; k <= 3; k++) hist[hist.size() - k] = reset_rec;
         #1;
         compare("rst_pixel_rgb",  32'(pixel_rgb),    32'h0);
         compare("rst_hsync_out",  32'(hsync_out),    32'h1);
         compare("rst_vsync_out",  32'(vsync_out),    32'h1);
         compare("rst_active_out", 32'(active_out),   32'h0);
         compare("rst_rom_addr",   32'(bus.rom_addr), 32'h20);
         compare("rst_tb_addr",    32'(bus.tb_addr),  32'h0);
      end else begin
`ifdef CURSOR_EN
         if (prev_vs && !vs) blink_edges++;
         prev_vs = vs;
`endif
         modelPixel(col, row, von, hs, vs, rec);
      end
      hist.push_back(rec);
      @(posedge CLK);
      #1;
      checkOutput();
   endtask

   task automatic scanRow(input int row, input int col0, input int n,
                          input bit von, input bit hs, input bit vs);
      for (int i = 0; i < n; i++) applyStimulus(col0 + i, row, von, hs, vs, 1'b0);
   endtask

   initial begin
      logic [7:0] codes [8];
      compared   = 0;
      mismatched = 0;
      last_addr  = 0;
`ifdef CURSOR_EN
      blink_edges = 0;
      prev_vs     = 1'b1;
`endif
      RST        = 1'b1;
      pixel_col  = '0;
      pixel_row  = '0;
      video_on   = 1'b0;
      hsync_in   = 1'b1;
      vsync_in   = 1'b1;
      cursor_col = 7'(CUR_COL);
      cursor_row = 6'(CUR_ROW);

      reset_rec = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, act: 1'b0, tba: 13'h0, roma: 8'h20};
      for (int k = 0; k < 3; k++) hist.push_back(reset_rec);

      // ROM: only a handful of codes have glyphs; everything else is blank.
      for (int c = 0; c < 256; c++)
         for (int r = 0; r < 8; r++) glyph[c][r] = 8'h00;
      for (int c = 'h40; c < 'h50; c++)
         for (int r = 0; r < 8; r++) glyph[c][r] = 8'($urandom);
      for (int r = 0; r < 8; r++) begin
         glyph['h31][r] = 8'($urandom) | 8'h01;
         glyph['h23][r] = 8'($urandom) | 8'h81;
      end
      glyph['h31][0] = 8'h0C;

      codes = '{8'h20, 8'h31, 8'h23, 8'h41, 8'h45, 8'h4A, 8'h4F, 8'h80};
      for (int i = 0; i < 8192; i++) tram[i] = 8'h20;
      for (int i = 0; i < COLS * ROWS; i++) tram[i] = codes[$urandom_range(0, 7)];
      tram[0]                      = 8'h31;
      tram[5]                      = 8'h23;
      tram[CUR_ROW * COLS + CUR_COL] = 8'h20;

      $display("[TB] reset");
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

      $display("[TB] glyph fetch cell (0,0) scan row 0");
      scanRow(0, 0, 8, 1'b1, 1'b1, 1'b1);
      scanRow(0, 8, 4, 1'b1, 1'b1, 1'b1);

      $display("[TB] addressing corners");
      applyStimulus(639, 479, 1'b1, 1'b1, 1'b1, 1'b0);
      compare("addr_4799", 32'(bus.tb_addr), 32'd4799);
      applyStimulus(8, 8, 1'b1, 1'b1, 1'b1, 1'b0);
      compare("addr_81", 32'(bus.tb_addr), 32'd81);
      scanRow(9, 100, 4, 1'b1, 1'b1, 1'b1);

      $display("[TB] blanking and out-of-range cells");
      scanRow(1, 40, 8, 1'b0, 1'b1, 1'b1);
      scanRow(3, 700, 8, 1'b1, 1'b1, 1'b1);
      scanRow(500, 16, 8, 1'b1, 1'b1, 1'b1);
      scanRow(0, 0, 4, 1'b0, 1'b1, 1'b1);

      $display("[TB] hsync pulse alignment");
      scanRow(0, 0, 3, 1'b0, 1'b1, 1'b1);
      scanRow(0, 3, 5, 1'b0, 1'b0, 1'b1);
      scanRow(0, 8, 6, 1'b0, 1'b1, 1'b1);

      $display("[TB] cursor blink frames");
      for (int f = 0; f < 4; f++) begin
         scanRow(23, 20, 16, 1'b1, 1'b1, 1'b1);
         scanRow(0, 0, 6, 1'b0, 1'b1, 1'b1);
         scanRow(0, 0, 3, 1'b0, 1'b1, 1'b0);
         scanRow(0, 0, 6, 1'b0, 1'b1, 1'b1);
      end

      $display("[TB] random pixels");
      for (int i = 0; i < 400; i++) begin
         int col, row;
         bit von, hs;
         col = (i % 5 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 660));
         row = (i % 7 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 500));
         von = ($urandom_range(0, 9) != 0);
         hs  = ($urandom_range(0, 5) != 0);
         applyStimulus(col, row, von, hs, 1'b1, 1'b0);
      end

      $display("[TB] mid-line reset");
      scanRow(10, 0, 10, 1'b1, 1'b1, 1'b1);
      applyStimulus(80, 10, 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(88, 10, 1'b1, 1'b0, 1'b1, 1'b1);
      scanRow(10, 96, 12, 1'b1, 1'b1, 1'b1);
      scanRow(0, 0, 5, 1'b0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
